// File: rtl/line_burst_pkg.sv
// Shared widths, state encoding and line/beat types for the line-to-burst adapter.
package line_burst_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_WIDTH   = $clog2(BEATS);

    // Clears the byte-within-line offset so bursts always start on a line boundary.
    localparam logic [ADDR_WIDTH-1:0] LINE_ADDR_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_DONE
    } adapter_state_t;

    typedef logic [BEAT_WIDTH-1:0] beat_t;
    typedef beat_t [BEATS-1:0]     line_t;
    typedef logic [CNT_WIDTH-1:0]  beat_cnt_t;

endpackage

// File: rtl/line_burst_adapter_beat_counter.sv
// Beat index within a burst; wraps to zero after the last beat so DONE starts clean.
module burst_beat_counter
    import line_burst_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      en,
    output beat_cnt_t cnt,
    output logic      last
);

    assign last = (cnt == beat_cnt_t'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + beat_cnt_t'(1);
        end
    end

endmodule

// File: rtl/line_burst_adapter.sv
// Turns one whole-line read/write into a fixed 4-beat burst on the narrow memory bus.
//
// state       | meaning
// ST_IDLE     | waiting for line_read/line_write; captures address and write data
// ST_RD_BURST | burst_read held; each acked beat lands in the line buffer
// ST_WR_BURST | burst_write held; beat data muxed from the captured line by cnt
// ST_DONE     | one-cycle line_resp, line_rdata = line buffer
module line_burst_adapter
    import line_burst_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [ADDR_WIDTH-1:0] line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    adapter_state_t        state;
    adapter_state_t        next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    line_t                 wdata_q;
    line_t                 line_buf;
    beat_cnt_t             cnt;
    logic                  cnt_last;
    logic                  in_burst;
    logic                  beat_done;

    assign in_burst  = (state == ST_RD_BURST) || (state == ST_WR_BURST);
    assign beat_done = in_burst && burst_resp;

    burst_beat_counter u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .en    (beat_done),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (line_write) begin
                    next_state = ST_WR_BURST;
                end else if (line_read) begin
                    next_state = ST_RD_BURST;
                end
            end
            ST_RD_BURST, ST_WR_BURST: begin
                if (beat_done && cnt_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Bursts are sourced only from these captures, so upstream may change freely once accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            line_buf <= '0;
        end else begin
            if (state == ST_IDLE && (line_read || line_write)) begin
                addr_q <= line_address;
            end
            if (state == ST_IDLE && line_write) begin
                wdata_q <= line_wdata;
            end
            if (state == ST_RD_BURST && burst_resp) begin
                line_buf[cnt] <= burst_rdata;
            end
        end
    end

    assign burst_read    = (state == ST_RD_BURST);
    assign burst_write   = (state == ST_WR_BURST);
    assign line_resp     = (state == ST_DONE);
    assign line_rdata    = line_buf;
    assign burst_address = addr_q & LINE_ADDR_MASK;
    assign burst_wdata   = (state == ST_WR_BURST) ? wdata_q[cnt] : '0;

    always_ff @(posedge clk) begin
        if (rst_n && state == ST_IDLE) begin
            assert (!(line_read && line_write))
                else $warning("line_burst_adapter: line_read and line_write both high, write taken");
        end
    end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench: bench-side memory slave plus a line-level reference image.
module tb_line_burst_adapter;
    import line_burst_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  line_read;
    logic                  line_write;
    logic [ADDR_WIDTH-1:0] line_address;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_resp;
    logic                  burst_read;
    logic                  burst_write;
    logic [ADDR_WIDTH-1:0] burst_address;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata;
    logic                  burst_resp;

    int checks = 0;
    int errors = 0;

    line_t ref_lines [logic [31:0]];
    beat_t mem       [logic [31:0]];

    always #5 clk = ~clk;

    line_burst_adapter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < BEATS; k++) l[k] = {$urandom, $urandom};
        return l;
    endfunction

    task automatic init_line(input logic [31:0] base, input line_t l);
        ref_lines[base] = l;
        for (int k = 0; k < BEATS; k++) mem[base + 32'(8 * k)] = l[k];
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input line_t wd,
                           input int stall_lo, input int stall_hi, input bit chg);
        bit          is_wr      = wr;
        logic [31:0] base       = {addr[31:5], 5'b0};
        line_t       exp_line   = '0;
        int          k          = 0;
        int          cyc        = 0;
        int          burst_cyc  = 0;
        int          stall_left;
        int          total_stall;
        bit          done       = 0;
        logic [31:0] beat_addr;

        @(negedge clk);
        checks++;
        if (burst_read !== 1'b0 || burst_write !== 1'b0 || line_resp !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_req: got rd=%b wr=%b resp=%b expected 0 0 0", burst_read, burst_write, line_resp);
        end
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wd;
        if (!is_wr) exp_line = ref_lines[base];
        stall_left  = $urandom_range(stall_hi, stall_lo);
        total_stall = stall_left;

        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (line_resp) begin
                done = 1;
                checks++;
                if (k !== BEATS) begin
                    errors++;
                    $display("FAIL beats_before_resp: got %0d expected %0d", k, BEATS);
                end
                checks++;
                if (cyc !== BEATS + total_stall + 1) begin
                    errors++;
                    $display("FAIL resp_latency: got cycle %0d expected %0d", cyc, BEATS + total_stall + 1);
                end
                if (!is_wr) begin
                    checks++;
                    if (line_rdata !== exp_line) begin
                        errors++;
                        $display("FAIL read_line: got %h expected %h", line_rdata, exp_line);
                    end
                end
                line_read  = 0;
                line_write = 0;
                burst_resp = 0;
            end else if (burst_read || burst_write) begin
                burst_cyc++;
                checks++;
                if (burst_write !== is_wr || burst_read !== !is_wr) begin
                    errors++;
                    $display("FAIL burst_dir: got rd=%b wr=%b expected wr=%b", burst_read, burst_write, is_wr);
                end
                checks++;
                if (burst_address !== base) begin
                    errors++;
                    $display("FAIL burst_address: got %h expected %h", burst_address, base);
                end
                if (is_wr && k < BEATS) begin
                    checks++;
                    if (burst_wdata !== wd[k]) begin
                        errors++;
                        $display("FAIL write_beat%0d: got %h expected %h", k, burst_wdata, wd[k]);
                    end
                end
                if (chg && burst_cyc == 1) begin
                    line_address = 32'hFFFF_FFE0;
                    line_wdata   = ~wd;
                end
                if (stall_left > 0) begin
                    burst_resp = 0;
                    stall_left--;
                end else begin
                    beat_addr  = base + 32'(8 * k);
                    burst_resp = 1;
                    if (is_wr) mem[beat_addr] = burst_wdata;
                    else       burst_rdata    = mem[beat_addr];
                    k++;
                    if (k < BEATS) begin
                        stall_left   = $urandom_range(stall_hi, stall_lo);
                        total_stall += stall_left;
                    end
                end
            end else begin
                burst_resp = 0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no line_resp within %0d cycles expected one", cyc);
            line_read  = 0;
            line_write = 0;
            burst_resp = 0;
        end
        if (is_wr) ref_lines[base] = wd;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (line_resp !== 0 || burst_read !== 0 || burst_write !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: got resp=%b rd=%b wr=%b expected 0 0 0", line_resp, burst_read, burst_write);
        end
        checks++;
        if (burst_address !== '0 || burst_wdata !== '0 || line_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", burst_address, burst_wdata, line_rdata);
        end
        rst_n = 1;
    endtask

    task automatic test_read_zero_stall();
        line_t l;
        l[0] = 64'h1111_1111_1111_1111;
        l[1] = 64'h2222_2222_2222_2222;
        l[2] = 64'h3333_3333_3333_3333;
        l[3] = 64'h4444_4444_4444_4444;
        init_line(32'h0000_1040, l);
        run_txn(1, 0, 32'h0000_104C, '0, 0, 0, 0);
    endtask

    task automatic test_write_stalls();
        line_t d;
        d[0] = 64'hD0D0_0000_0000_00D0;
        d[1] = 64'hD1D1_1111_0000_00D1;
        d[2] = 64'hD2D2_2222_0000_00D2;
        d[3] = 64'hD3D3_3333_0000_00D3;
        run_txn(0, 1, 32'h0000_2000, d, 2, 2, 0);
        run_txn(1, 0, 32'h0000_2000, '0, 0, 0, 0);
    endtask

    task automatic test_addr_change();
        run_txn(1, 0, 32'h0000_104C, '0, 0, 1, 1);
        run_txn(0, 1, 32'h0000_1040, rand_line(), 0, 1, 1);
        run_txn(1, 0, 32'h0000_1040, '0, 0, 0, 0);
    endtask

    task automatic test_read_write_collision();
        init_line(32'h0000_3000, rand_line());
        run_txn(1, 1, 32'h0000_3000, rand_line(), 0, 0, 0);
        run_txn(1, 0, 32'h0000_3000, '0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        init_line(32'h0000_6000, rand_line());
        @(negedge clk);
        line_read    = 1;
        line_address = 32'h0000_6000;
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            if (burst_read) begin
                burst_rdata = mem[32'h0000_6000 + 32'(8 * k)];
                burst_resp  = 1;
                k++;
            end else begin
                burst_resp = 0;
            end
        end
        @(negedge clk);
        checks++;
        if (burst_read !== 1'b1 || k !== 2) begin
            errors++;
            $display("FAIL mid_burst_active: got rd=%b beats=%0d expected 1 2", burst_read, k);
        end
        rst_n      = 0;
        burst_resp = 0;
        line_read  = 0;
        @(negedge clk);
        checks++;
        if (burst_read !== 0 || line_resp !== 0 || line_rdata !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: got rd=%b resp=%b rdata=%h expected 0 0 0", burst_read, line_resp, line_rdata);
        end
        rst_n = 1;
        run_txn(1, 0, 32'h0000_6000, '0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_txn(0, 1, 32'h0000_5008, rand_line(), 0, 0, 0);
        run_txn(1, 0, 32'h0000_5000, '0, 0, 0, 0);
        run_txn(0, 1, 32'h0000_5000, rand_line(), 0, 2, 0);
        run_txn(1, 0, 32'h0000_5010, '0, 0, 2, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) init_line(32'h8000_0000 + 32'(i * 32), rand_line());
        for (int n = 0; n < 24; n++) begin
            a = 32'h8000_0000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) run_txn(0, 1, a, rand_line(), 0, 3, $urandom_range(0, 1) == 1);
            else                           run_txn(1, 0, a, '0, 0, 3, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        line_read    = 0;
        line_write   = 0;
        line_address = '0;
        line_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 0;
        test_reset();
        test_read_zero_stall();
        test_write_stalls();
        test_addr_change();
        test_read_write_collision();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
